spi_wb_burst_bridge: RTL and testbench

SPI-slave (mode 0) to Wishbone-classic master bridge with configurable address and data widths, and burst transfers with address auto-increment. It is the next generation of the single-byte SPI/Wishbone bridge and sits between the chip's SPI pins and the internal Wishbone register/memory fabric. A frame carries one header followed by any number of data words. Wishbone status is reported per read word, write overrun is flagged, and an optional Wishbone timeout is available.

---
 rtl/spi_wb_burst_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_wb_burst_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_burst_bridge.sv
// SPI-slave (mode 0) to Wishbone-classic master bridge with burst transfers.
//
// A frame (spi_ss_n low) carries a header of 1+ADDR_W bits, MSB first: a write
// flag followed by the word address. Write frames then carry DATA_W-bit words,
// each issued as one Wishbone write with address auto-increment. Read frames
// return, per word, a 1 marker, a 2-bit status and DATA_W data bits; the next
// read is prefetched as soon as the current word has been shifted out.
//
// Optional feature: define SPI_WB_TIMEOUT_EN to enable a Wishbone watchdog that
// forces a termination (status 11, data 0) after TIMEOUT_CYCLES clocks.
//
// Ports:
//   clk_i, rst_ni                    system clock, async active-low reset
//   spi_sck, spi_ss_n, spi_mosi      asynchronous SPI inputs
//   spi_miso                         SPI data out (registered)
//   cyc_o, stb_o, we_o, adr_o, dat_o Wishbone master request
//   dat_i, ack_i, err_i, rty_i       Wishbone slave response
//   overrun_o                        sticky write-overrun flag, cleared at frame start
module spi_wb_burst_bridge #(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic              rty_i,
  output logic              overrun_o
);

  localparam int unsigned HdrBits = ADDR_W + 1;
  localparam int unsigned TxBits  = DATA_W + 3;
  localparam int unsigned CntMax  = (HdrBits > TxBits) ? HdrBits : TxBits;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StWrite,
    StReadWait,
    StReadShift,
    StDrain
  } state_e;

  // Input synchronisers
  logic [1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
  logic       sck_prev_q;
  logic       sck_rise, mosi_s, ss_n_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      ss_sync_q   <= 2'b11;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      ss_sync_q   <= {ss_sync_q[0], spi_ss_n};
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign mosi_s   = mosi_sync_q[1];
  assign ss_n_s   = ss_sync_q[1];

  // Registered state and outputs
  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [ADDR_W-1:0]   hdr_q;    // header bits received so far (last bit arrives live)
  logic [DATA_W-2:0]   rx_q;     // write word bits received so far
  logic [TxBits-1:0]   tx_q;     // {marker, status, data} for read shift-out
  logic [ADDR_W-1:0]   addr_q;   // write: next address; read: outstanding read address
  logic                cyc_q;
  logic                miso_q;

  // Wishbone termination, err > rty > ack > timeout
  logic              timeout;
  logic              term;
  logic [1:0]        term_status;
  logic [DATA_W-1:0] term_data;

`ifdef SPI_WB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (!cyc_q) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + ToW'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th clock of the cycle, so cyc_o is high that many clocks.
  assign timeout = cyc_q && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign term = cyc_q & (ack_i | err_i | rty_i | timeout);

  always_comb begin
    term_status = 2'b11;
    term_data   = '0;
    if (err_i) begin
      term_status = 2'b10;
    end else if (rty_i) begin
      term_status = 2'b01;
    end else if (ack_i) begin
      term_status = 2'b00;
      term_data   = dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hdr_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      cyc_q     <= 1'b0;
      miso_q    <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      overrun_o <= 1'b0;
    end else begin
      // Any termination ends the cycle; branches below only raise cyc_q when it was low.
      if (term) begin
        cyc_q <= 1'b0;
      end

      if (ss_n_s && (state_q != StIdle) && (state_q != StDrain)) begin
        // Frame end: a partial word is simply abandoned.
        miso_q  <= 1'b0;
        state_q <= (cyc_q && !term) ? StDrain : StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            miso_q <= 1'b0;
            if (!ss_n_s) begin
              state_q   <= StHeader;
              cnt_q     <= '0;
              overrun_o <= 1'b0;
            end
          end

          StHeader: begin
            if (sck_rise) begin
              miso_q <= 1'b0;
              hdr_q  <= {hdr_q[ADDR_W-2:0], mosi_s};
              cnt_q  <= cnt_q + CntW'(1);
              if (cnt_q == CntW'(ADDR_W)) begin
                cnt_q  <= '0;
                we_o   <= hdr_q[ADDR_W-1];
                addr_q <= {hdr_q[ADDR_W-2:0], mosi_s};
                if (hdr_q[ADDR_W-1]) begin
                  state_q <= StWrite;
                end else begin
                  adr_o   <= {hdr_q[ADDR_W-2:0], mosi_s};
                  cyc_q   <= 1'b1;
                  state_q <= StReadWait;
                end
              end
            end
          end

          StWrite: begin
            if (sck_rise) begin
              miso_q <= ~cyc_q;
              rx_q   <= {rx_q[DATA_W-3:0], mosi_s};
              cnt_q  <= cnt_q + CntW'(1);
              if (cnt_q == CntW'(DATA_W - 1)) begin
                cnt_q <= '0;
                if (!cyc_q) begin
                  dat_o  <= {rx_q, mosi_s};
                  adr_o  <= addr_q;
                  addr_q <= addr_q + ADDR_W'(1);
                  cyc_q  <= 1'b1;
                end else begin
                  // Previous write still outstanding: this word is lost.
                  overrun_o <= 1'b1;
                end
              end
            end
          end

          StReadWait: begin
            if (sck_rise) begin
              miso_q <= 1'b0;
            end
            if (term) begin
              tx_q    <= {1'b1, term_status, term_data};
              cnt_q   <= '0;
              state_q <= StReadShift;
            end
          end

          StReadShift: begin
            if (sck_rise) begin
              miso_q <= tx_q[TxBits-1];
              tx_q   <= tx_q << 1;
              cnt_q  <= cnt_q + CntW'(1);
              if (cnt_q == CntW'(TxBits - 1)) begin
                // Prefetch the next word while the host finishes this one.
                cnt_q   <= '0;
                addr_q  <= addr_q + ADDR_W'(1);
                adr_o   <= addr_q + ADDR_W'(1);
                cyc_q   <= 1'b1;
                state_q <= StReadWait;
              end
            end
          end

          StDrain: begin
            miso_q <= 1'b0;
            if (term) begin
              state_q <= StIdle;
            end
          end

          default: begin
            state_q <= StIdle;
            cyc_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_wb_burst_bridge.sv
// Self-checking bench for spi_wb_burst_bridge (ADDR_W=23, DATA_W=8).
// Expected Wishbone requests and read words are queued when stimulus is
// planned and checked when the DUT issues a cycle or shifts a word out.
module tb_spi_wb_burst_bridge;

  localparam int AW = 23;
  localparam int DW = 8;
  localparam int H  = 6;  // SCK half period in clk_i cycles

  logic          clk_i, rst_ni;
  logic          spi_sck, spi_ss_n, spi_mosi, spi_miso;
  logic          cyc_o, stb_o, we_o, overrun_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o, dat_i;
  logic          ack_i, err_i, rty_i;

  spi_wb_burst_bridge #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .spi_sck  (spi_sck),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .cyc_o    (cyc_o),
    .stb_o    (stb_o),
    .we_o     (we_o),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .dat_i    (dat_i),
    .ack_i    (ack_i),
    .err_i    (err_i),
    .rty_i    (rty_i),
    .overrun_o(overrun_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 ack, 1 rty, 2 err, 3 no termination
  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [1:0]    kind;
    int            delay;
    logic [DW-1:0] rdata;
  } wb_exp_t;

  typedef struct {
    logic [1:0]    st;
    logic [DW-1:0] data;
  } rd_exp_t;

  wb_exp_t wb_q[$];
  rd_exp_t rd_q[$];
  int      cyc_len;

  task automatic plan_wb(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [1:0] kind, input int delay, input logic [DW-1:0] rdata,
                         input logic host_reads);
    rd_exp_t r;
    wb_q.push_back('{we: we, adr: adr, dat: dat, kind: kind, delay: delay, rdata: rdata});
    if (host_reads) begin
      r.st   = kind;
      r.data = (kind == 2'd0) ? rdata : '0;
      rd_q.push_back(r);
    end
  endtask

  // Wishbone slave: checks each new cycle against the queue and terminates it as planned.
  initial begin
    wb_exp_t cur;
    logic    active;
    int      cnt;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
    active = 1'b0; cnt = 0; cyc_len = 0;
    cur = '{we: 1'b0, adr: '0, dat: '0, kind: 2'd0, delay: 1, rdata: '0};
    forever begin
      @(negedge clk_i);
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
      if (cyc_o) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          check_eq("wb_cycle_expected", (wb_q.size() != 0), 1);
          if (wb_q.size() != 0) begin
            cur = wb_q.pop_front();
            check_eq("wb_we", we_o, cur.we);
            check_eq("wb_adr", adr_o, cur.adr);
            check_eq("wb_stb", stb_o, 1'b1);
            if (cur.we) check_eq("wb_dat", dat_o, cur.dat);
          end else begin
            cur = '{we: 1'b0, adr: '0, dat: '0, kind: 2'd0, delay: 1, rdata: '0};
          end
        end
        cnt++;
        if (cur.kind != 2'd3 && cnt >= cur.delay) begin
          dat_i = cur.rdata;
          case (cur.kind)
            2'd0:    ack_i = 1'b1;
            2'd1:    rty_i = 1'b1;
            default: err_i = 1'b1;
          endcase
        end
      end else if (active) begin
        cyc_len = cnt;
        active  = 1'b0;
      end
    end
  end

  // SPI host, mode 0: drive mosi, raise sck, sample miso at the falling edge.
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (H) @(negedge clk_i);
    spi_sck = 1'b1;
    repeat (H) @(negedge clk_i);
    m = spi_miso;
    spi_sck = 1'b0;
  endtask

  task automatic spi_start();
    spi_ss_n = 1'b0;
    repeat (H) @(negedge clk_i);
  endtask

  task automatic spi_stop();
    repeat (H) @(negedge clk_i);
    spi_ss_n = 1'b1;
    repeat (20) @(negedge clk_i);
  endtask

  task automatic send_header(input logic we, input logic [AW-1:0] adr);
    logic [AW:0] h;
    logic        m;
    h = {we, adr};
    for (int i = AW; i >= 0; i--) spi_bit(h[i], m);
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    logic m;
    for (int i = DW - 1; i >= 0; i--) spi_bit(d[i], m);
  endtask

  task automatic read_and_check();
    logic          m, found;
    logic [1:0]    st;
    logic [DW-1:0] d;
    rd_exp_t       e;
    found = 1'b0; st = '0; d = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      spi_bit(1'b0, m);
      if (m) found = 1'b1;
    end
    check_eq("rd_marker_found", found, 1'b1);
    if (found) begin
      for (int i = 0; i < 2; i++) begin spi_bit(1'b0, m); st = {st[0], m}; end
      for (int i = 0; i < DW; i++) begin spi_bit(1'b0, m); d = {d[DW-2:0], m}; end
    end
    check_eq("rd_word_expected", (rd_q.size() != 0), 1);
    if (rd_q.size() != 0) begin
      e = rd_q.pop_front();
      check_eq("rd_status", st, e.st);
      check_eq("rd_data", d, e.data);
    end
  endtask

  task automatic wait_cyc_low(input string tag, input int budget);
    int n;
    n = 0;
    while (cyc_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check_eq(tag, cyc_o, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic m;
    rst_ni = 1'b0; spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    repeat (4) @(negedge clk_i);
    #1;
    check_eq("rst_miso", spi_miso, 1'b0);
    check_eq("rst_cyc", cyc_o, 1'b0);
    check_eq("rst_stb", stb_o, 1'b0);
    check_eq("rst_we", we_o, 1'b0);
    check_eq("rst_adr", adr_o, '0);
    check_eq("rst_dat", dat_o, '0);
    check_eq("rst_overrun", overrun_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    // Single write
    plan_wb(1'b1, 23'h000010, 8'hA5, 2'd0, 2, '0, 1'b0);
    spi_start();
    send_header(1'b1, 23'h000010);
    send_word(8'hA5);
    spi_stop();
    check_eq("single_overrun", overrun_o, 1'b0);

    // Write burst with address wrap
    plan_wb(1'b1, 23'h7FFFFF, 8'h01, 2'd0, 1, '0, 1'b0);
    plan_wb(1'b1, 23'h000000, 8'h02, 2'd0, 1, '0, 1'b0);
    plan_wb(1'b1, 23'h000001, 8'h03, 2'd0, 1, '0, 1'b0);
    spi_start();
    send_header(1'b1, 23'h7FFFFF);
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    spi_stop();

    // Read burst: ack with data, then err (data must read back as 0), then a prefetch
    plan_wb(1'b0, 23'h000020, '0, 2'd0, 2, 8'h3C, 1'b1);
    plan_wb(1'b0, 23'h000021, '0, 2'd2, 2, 8'h77, 1'b1);
    plan_wb(1'b0, 23'h000022, '0, 2'd0, 3, 8'h99, 1'b0);
    spi_start();
    send_header(1'b0, 23'h000020);
    read_and_check();
    read_and_check();
    spi_stop();

    // Overrun: first write stalls, second word dropped, third goes to 0x21
    plan_wb(1'b1, 23'h000020, 8'h11, 2'd0, 100, '0, 1'b0);
    plan_wb(1'b1, 23'h000021, 8'h33, 2'd0, 1, '0, 1'b0);
    spi_start();
    send_header(1'b1, 23'h000020);
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    spi_stop();
    check_eq("overrun_set", overrun_o, 1'b1);

    // Drain: ss_n released with a read outstanding; new select during drain ignored
    plan_wb(1'b0, 23'h000040, '0, 2'd0, 60, 8'h5A, 1'b0);
    spi_start();
    check_eq("overrun_cleared", overrun_o, 1'b0);
    send_header(1'b0, 23'h000040);
    repeat (H) @(negedge clk_i);
    spi_ss_n = 1'b1;
    repeat (10) @(negedge clk_i);
    check_eq("drain_hold", cyc_o, 1'b1);
    spi_ss_n = 1'b0;
    spi_bit(1'b1, m);
    check_eq("drain_miso0", m, 1'b0);
    spi_bit(1'b1, m);
    check_eq("drain_miso1", m, 1'b0);
    spi_ss_n = 1'b1;
    wait_cyc_low("drain_release", 300);
    repeat (30) @(negedge clk_i);
    check_eq("drain_no_new_cycle", cyc_o, 1'b0);

`ifdef SPI_WB_TIMEOUT_EN
    // Timeout: no termination, cycle forced off after 16 clk, status 11
    plan_wb(1'b0, 23'h000050, '0, 2'd3, 0, '0, 1'b1);
    plan_wb(1'b0, 23'h000051, '0, 2'd3, 0, '0, 1'b0);
    spi_start();
    send_header(1'b0, 23'h000050);
    read_and_check();
    check_eq("timeout_len", cyc_len, 16);
    spi_stop();
    wait_cyc_low("timeout_drain_release", 100);
    repeat (10) @(negedge clk_i);
`endif

    check_eq("wb_queue_empty", wb_q.size(), 0);
    check_eq("rd_queue_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
